ysyx_22050598_axi_m: RTL and testbench

AXI4 master bridge translating a single-outstanding cache/LSU request into AXI4 read or write bursts of one or two 64-bit beats. It is the initiator counterpart of the simulation memory slave on the same bus. It sits between the core's memory-request port and the AXI interconnect/slave. It serializes reads and writes through one FSM, one transaction at a time.

---
 rtl/ysyx_22050598_axi_m.sv | 205 ++++++++++++++++++++
 tb/tb_ysyx_22050598_axi_m.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050598_axi_m.sv
// AXI4 master bridge: one outstanding cache/LSU request becomes a one- or two-beat 64-bit burst.
// Optional bus watchdog enabled by defining YSYX_22050598_AXI_M_TIMEOUT_EN.
module ysyx_22050598_axi_m #(
    parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64
) (
    input  logic                                  M_AXI_ACLK,
    input  logic                                  M_AXI_ARESET,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_wen,
    input  logic                                  req_len,
    input  logic [2:0]                            req_size,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]         req_addr,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0]       req_wdata,
    input  logic [2*C_M_AXI_DATA_WIDTH/8-1:0]     req_wstrb,
    output logic                                  resp_valid,
    input  logic                                  resp_ready,
    output logic [2*C_M_AXI_DATA_WIDTH-1:0]       resp_rdata,
    output logic                                  resp_err,
    output logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic [7:0]                            M_AXI_AWLEN,
    output logic [2:0]                            M_AXI_AWSIZE,
    output logic [1:0]                            M_AXI_AWBURST,
    output logic                                  M_AXI_AWLOCK,
    output logic [3:0]                            M_AXI_AWCACHE,
    output logic [2:0]                            M_AXI_AWPROT,
    output logic [3:0]                            M_AXI_AWQOS,
    output logic                                  M_AXI_AWVALID,
    input  logic                                  M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
    output logic                                  M_AXI_WLAST,
    output logic                                  M_AXI_WVALID,
    input  logic                                  M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_BID,
    input  logic [1:0]                            M_AXI_BRESP,
    input  logic                                  M_AXI_BVALID,
    output logic                                  M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic [7:0]                            M_AXI_ARLEN,
    output logic [2:0]                            M_AXI_ARSIZE,
    output logic [1:0]                            M_AXI_ARBURST,
    output logic                                  M_AXI_ARLOCK,
    output logic [3:0]                            M_AXI_ARCACHE,
    output logic [2:0]                            M_AXI_ARPROT,
    output logic [3:0]                            M_AXI_ARQOS,
    output logic                                  M_AXI_ARVALID,
    input  logic                                  M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                            M_AXI_RRESP,
    input  logic                                  M_AXI_RLAST,
    input  logic                                  M_AXI_RVALID,
    output logic                                  M_AXI_RREADY
);
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB, StResp} state_e;

    state_e                          state_q;
    logic                            len_q;
    logic [2:0]                      ax_size_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   ax_addr_q;
    logic [2*DW-1:0]                 wdata_q;
    logic [2*SW-1:0]                 wstrb_q;
    logic [2*DW-1:0]                 rdata_q;
    logic                            beat_cnt_q;
    logic                            err_q;
    logic                            drop_q;

    // IDs are constant, so returned IDs carry no information.
    logic unused_id;
    assign unused_id = ^{M_AXI_BID, M_AXI_RID};

`ifdef YSYX_22050598_AXI_M_TIMEOUT_EN
    logic [9:0] wdog_q;
    logic       bus_hs;
    assign bus_hs = (M_AXI_ARVALID & M_AXI_ARREADY) | (M_AXI_RREADY & M_AXI_RVALID) |
                    (M_AXI_AWVALID & M_AXI_AWREADY) | (M_AXI_WVALID & M_AXI_WREADY) |
                    (M_AXI_BREADY & M_AXI_BVALID);
`endif

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q    <= StIdle;
            len_q      <= 1'b0;
            ax_size_q  <= 3'b000;
            ax_addr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            beat_cnt_q <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
`ifdef YSYX_22050598_AXI_M_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        len_q     <= req_len;
                        ax_size_q <= req_len ? 3'b011 : req_size;
                        ax_addr_q <= req_len ? {req_addr[C_M_AXI_ADDR_WIDTH-1:4], 4'b0000}
                                             : req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        rdata_q   <= '0;
                        state_q   <= req_wen ? StAw : StAr;
                    end
                end
                StAr: if (M_AXI_ARREADY) state_q <= StR;
                StR: begin
                    if (M_AXI_RVALID) begin
                        // Beats past the expected last one are accepted but discarded.
                        if (!drop_q) begin
                            if (beat_cnt_q) rdata_q[DW +: DW] <= M_AXI_RDATA;
                            else            rdata_q[0 +: DW]  <= M_AXI_RDATA;
                        end
                        if ((M_AXI_RRESP != 2'b00) ||
                            (!drop_q && (M_AXI_RLAST != (beat_cnt_q == len_q)))) begin
                            err_q <= 1'b1;
                        end
                        if (!M_AXI_RLAST && (beat_cnt_q == len_q)) drop_q <= 1'b1;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (M_AXI_RLAST) state_q <= StResp;
                    end
                end
                StAw: if (M_AXI_AWREADY) state_q <= StW;
                StW: begin
                    if (M_AXI_WREADY) begin
                        if (M_AXI_WLAST) state_q <= StB;
                        else             beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                StB: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00) err_q <= 1'b1;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        beat_cnt_q <= 1'b0;
                        err_q      <= 1'b0;
                        drop_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef YSYX_22050598_AXI_M_TIMEOUT_EN
            if (state_q == StIdle || state_q == StResp || bus_hs) begin
                wdog_q <= '0;
            end else if (wdog_q == 10'h3ff) begin
                wdog_q  <= '0;
                err_q   <= 1'b1;
                state_q <= StResp;
            end else begin
                wdog_q <= wdog_q + 10'd1;
            end
`endif
        end
    end

    assign req_ready     = (state_q == StIdle) && !M_AXI_ARESET;
    assign resp_valid    = (state_q == StResp);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = ax_addr_q;
    assign M_AXI_ARLEN   = {7'b0, len_q};
    assign M_AXI_ARSIZE  = ax_size_q;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARVALID = (state_q == StAr);
    assign M_AXI_RREADY  = (state_q == StR);

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = ax_addr_q;
    assign M_AXI_AWLEN   = {7'b0, len_q};
    assign M_AXI_AWSIZE  = ax_size_q;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0000;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWVALID = (state_q == StAw);

    assign M_AXI_WDATA   = beat_cnt_q ? wdata_q[DW +: DW] : wdata_q[0 +: DW];
    assign M_AXI_WSTRB   = beat_cnt_q ? wstrb_q[SW +: SW] : wstrb_q[0 +: SW];
    assign M_AXI_WLAST   = (beat_cnt_q == len_q);
    assign M_AXI_WVALID  = (state_q == StW);
    assign M_AXI_BREADY  = (state_q == StB);

endmodule

// File: tb/tb_ysyx_22050598_axi_m.sv
// Bench for ysyx_22050598_axi_m: scripted AXI slave, expected completions queued per request.
`timescale 1ns/1ps
module tb_ysyx_22050598_axi_m;
    logic         clk;
    logic         rst;
    logic         req_valid, req_ready, req_wen, req_len;
    logic [2:0]   req_size;
    logic [63:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_wstrb;
    logic         resp_valid, resp_ready, resp_err;
    logic [127:0] resp_rdata;
    logic [0:0]   awid, arid, bid, rid;
    logic [63:0]  awaddr, araddr, wdata, rdata;
    logic [7:0]   awlen, arlen, wstrb;
    logic [2:0]   awsize, arsize, awprot, arprot;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic [3:0]   awcache, arcache, awqos, arqos;
    logic         awlock, arlock, awvalid, awready, wlast, wvalid, wready;
    logic         bvalid, bready, arvalid, arready, rlast, rvalid, rready;

    typedef struct {
        logic [127:0] rdata;
        logic         err;
    } exp_t;
    exp_t sb_q[$];

    int n_vec = 0;
    int n_bad = 0;

    ysyx_22050598_axi_m dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_len(req_len),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
        .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request and return at the falling edge of the cycle after acceptance.
    task automatic issue(input logic wen, input logic len, input logic [2:0] size,
                         input logic [63:0] addr, input logic [127:0] wd, input logic [15:0] ws);
        req_wen = wen; req_len = len; req_size = size; req_addr = addr;
        req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output bit seen, output int cycles);
        cycles = 0;
        while (!resp_valid && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        seen = resp_valid;
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic r_beat(input logic [63:0] d, input logic [1:0] r, input logic last);
        rvalid = 1'b1; rdata = d; rresp = r; rlast = last;
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_ready, arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err} !== 8'b0)
        begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {req_ready, arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err});
        end
        n_vec++;
        if (resp_rdata !== 128'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", resp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        sb_q.push_back('{rdata: {64'h0, 64'h1122334455667788}, err: 1'b0});
        issue(1'b0, 1'b0, 3'b011, 64'h8000_0008, 128'h0, 16'h0);
        n_vec++;
        if ({arvalid, araddr, arlen, arsize, arburst} !== {1'b1, 64'h8000_0008, 8'd0, 3'b011, 2'b01})
        begin
            n_bad++;
            $display("FAIL single_ar: got v=%b a=%h l=%h s=%h b=%h want v=1 a=80000008 l=0 s=3 b=1",
                     arvalid, araddr, arlen, arsize, arburst);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        n_vec++;
        if ({arvalid, rready} !== 2'b01) begin
            n_bad++; $display("FAIL single_r_phase: got ar=%b rr=%b want ar=0 rr=1", arvalid, rready);
        end
        r_beat(64'h1122334455667788, 2'b00, 1'b1);
        n_vec++;
        if (resp_valid !== 1'b1) begin
            n_bad++; $display("FAIL single_latency: got resp_valid=%b want 1 at N+3", resp_valid);
        end
        e = sb_q.pop_front();
        n_vec++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            n_bad++;
            $display("FAIL single_resp: got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
        end
        ack_resp();
        n_vec++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_bad++; $display("FAIL single_release: got rdy=%b rv=%b want 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_line_read();
        exp_t e;
        sb_q.push_back('{rdata: {64'hB, 64'hA}, err: 1'b0});
        issue(1'b0, 1'b1, 3'b010, 64'h8000_001C, 128'h0, 16'h0);
        n_vec++;
        if ({araddr, arlen, arsize} !== {64'h8000_0010, 8'd1, 3'b011}) begin
            n_bad++;
            $display("FAIL line_ar: got a=%h l=%h s=%h want a=80000010 l=1 s=3", araddr, arlen, arsize);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        r_beat(64'hA, 2'b00, 1'b0);
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL line_early_resp: got resp_valid=%b want 0 at N+3", resp_valid);
        end
        r_beat(64'hB, 2'b00, 1'b1);
        n_vec++;
        if (resp_valid !== 1'b1) begin
            n_bad++; $display("FAIL line_latency: got resp_valid=%b want 1 at N+4", resp_valid);
        end
        e = sb_q.pop_front();
        n_vec++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            n_bad++;
            $display("FAIL line_resp: got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
        end
        ack_resp();
    endtask

    task automatic test_line_write();
        exp_t e;
        sb_q.push_back('{rdata: 128'h0, err: 1'b0});
        issue(1'b1, 1'b1, 3'b011, 64'h8000_0048, {64'hD, 64'hC}, 16'hFF0F);
        n_vec++;
        if ({awvalid, wvalid, awaddr, awlen, awsize} !== {2'b10, 64'h8000_0040, 8'd1, 3'b011}) begin
            n_bad++;
            $display("FAIL write_aw: got awv=%b wv=%b a=%h l=%h s=%h want 1 0 80000040 1 3",
                     awvalid, wvalid, awaddr, awlen, awsize);
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        n_vec++;
        if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 64'hC, 8'h0F, 1'b0}) begin
            n_bad++;
            $display("FAIL write_beat0: got v=%b d=%h s=%h l=%b want 1 c 0f 0", wvalid, wdata, wstrb, wlast);
        end
        wready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 64'hD, 8'hFF, 1'b1}) begin
            n_bad++;
            $display("FAIL write_beat1: got v=%b d=%h s=%h l=%b want 1 d ff 1", wvalid, wdata, wstrb, wlast);
        end
        @(negedge clk);
        wready = 1'b0;
        n_vec++;
        if ({wvalid, bready} !== 2'b01) begin
            n_bad++; $display("FAIL write_b_phase: got wv=%b br=%b want 0 1", wvalid, bready);
        end
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        e = sb_q.pop_front();
        n_vec++;
        if (resp_valid !== 1'b1 || resp_err !== e.err) begin
            n_bad++;
            $display("FAIL write_resp: got rv=%b err=%b want rv=1 err=%b", resp_valid, resp_err, e.err);
        end
        ack_resp();
    endtask

    task automatic test_bresp_err();
        exp_t e;
        sb_q.push_back('{rdata: 128'h0, err: 1'b1});
        issue(1'b1, 1'b0, 3'b011, 64'h8000_0000, {64'h0, 64'h55}, 16'h00FF);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        n_vec++;
        if ({wvalid, wlast, wdata} !== {2'b11, 64'h55}) begin
            n_bad++; $display("FAIL bresp_w: got v=%b l=%b d=%h want 1 1 55", wvalid, wlast, wdata);
        end
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        e = sb_q.pop_front();
        n_vec++;
        if (resp_valid !== 1'b1 || resp_err !== e.err) begin
            n_bad++;
            $display("FAIL bresp_err: got rv=%b err=%b want rv=1 err=%b", resp_valid, resp_err, e.err);
        end
        ack_resp();
    endtask

    task automatic test_rlast_early();
        exp_t e;
        sb_q.push_back('{rdata: 128'h0, err: 1'b1});
        issue(1'b0, 1'b1, 3'b011, 64'h8000_0100, 128'h0, 16'h0);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        r_beat(64'h77, 2'b00, 1'b1);
        e = sb_q.pop_front();
        n_vec++;
        if (resp_valid !== 1'b1 || resp_err !== e.err) begin
            n_bad++;
            $display("FAIL rlast_early: got rv=%b err=%b want rv=1 err=%b", resp_valid, resp_err, e.err);
        end
        ack_resp();
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rlast_early_idle: got req_ready=%b want 1", req_ready);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        sb_q.push_back('{rdata: {64'h0, 64'hCAFE}, err: 1'b0});
        issue(1'b0, 1'b0, 3'b010, 64'h8000_0204, 128'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({arvalid, araddr, req_ready} !== {1'b1, 64'h8000_0204, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_ar_hold%0d: got v=%b a=%h rdy=%b want 1 80000204 0",
                         i, arvalid, araddr, req_ready);
            end
            @(negedge clk);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        r_beat(64'hCAFE, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({resp_valid, req_ready} !== 2'b10) begin
                n_bad++;
                $display("FAIL bp_resp_hold%0d: got rv=%b rdy=%b want 1 0", i, resp_valid, req_ready);
            end
            @(negedge clk);
        end
        e = sb_q.pop_front();
        n_vec++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            n_bad++;
            $display("FAIL bp_resp: got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
        end
        ack_resp();
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: got req_ready=%b want 1", req_ready);
        end
    endtask

    // Single reads issued back to back with random payload and random slave error.
    task automatic test_back_to_back();
        exp_t e;
        logic [63:0] a, d;
        logic [2:0]  sz;
        logic        bad;
        bit          seen;
        int          cyc;
        for (int i = 0; i < 6; i++) begin
            a   = {32'h8000_0000, $urandom};
            d   = {$urandom, $urandom};
            sz  = 3'($urandom_range(0, 3));
            bad = 1'($urandom_range(0, 1));
            n_vec++;
            if (req_ready !== 1'b1) begin
                n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready);
            end
            sb_q.push_back('{rdata: {64'h0, d}, err: bad});
            issue(1'b0, 1'b0, sz, a, 128'h0, 16'h0);
            n_vec++;
            if ({araddr, arsize} !== {a, sz}) begin
                n_bad++;
                $display("FAIL b2b_ar%0d: got a=%h s=%h want a=%h s=%h", i, araddr, arsize, a, sz);
            end
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0;
            r_beat(d, bad ? 2'b10 : 2'b00, 1'b1);
            wait_resp(10, seen, cyc);
            e = sb_q.pop_front();
            n_vec++;
            if (!seen || resp_rdata !== e.rdata || resp_err !== e.err) begin
                n_bad++;
                $display("FAIL b2b_resp%0d: got seen=%b %h/%b want %h/%b",
                         i, seen, resp_rdata, resp_err, e.rdata, e.err);
            end
            ack_resp();
        end
    endtask

    task automatic test_reset_mid_w();
        issue(1'b1, 1'b1, 3'b011, 64'h8000_0300, {64'h2, 64'h1}, 16'hFFFF);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        n_vec++;
        if (wvalid !== 1'b1) begin
            n_bad++; $display("FAIL midw_in_w: got wvalid=%b want 1", wvalid);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({arvalid, awvalid, wvalid, rready, bready, resp_valid} !== 6'b0) begin
            n_bad++;
            $display("FAIL midw_drop: got %b want 000000",
                     {arvalid, awvalid, wvalid, rready, bready, resp_valid});
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL midw_idle: got req_ready=%b want 1", req_ready);
        end
    endtask

`ifdef YSYX_22050598_AXI_M_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        bit   seen;
        int   cyc;
        sb_q.push_back('{rdata: 128'h0, err: 1'b1});
        issue(1'b0, 1'b0, 3'b011, 64'h8000_0400, 128'h0, 16'h0);
        wait_resp(1100, seen, cyc);
        e = sb_q.pop_front();
        n_vec++;
        if (!seen || resp_err !== e.err || arvalid !== 1'b0 || cyc < 1020 || cyc > 1030) begin
            n_bad++;
            $display("FAIL timeout: got seen=%b err=%b arv=%b cycles=%0d want 1 1 0 ~1024",
                     seen, resp_err, arvalid, cyc);
        end
        ack_resp();
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_len = 1'b0; req_size = 3'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bid = '0; bresp = 2'b00; bvalid = 1'b0;
        rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        test_reset();
        test_single_read();
        test_line_read();
        test_line_write();
        test_bresp_err();
        test_rlast_early();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_w();
`ifdef YSYX_22050598_AXI_M_TIMEOUT_EN
        test_timeout();
`endif
        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
